// File: rtl/credit_wrr_scheduler.sv
// Packet-level weighted round-robin scheduler for one router output port.
// Grants are locked for a whole packet and flits are gated on downstream credits.
module credit_wrr_scheduler #(
    parameter int CHANNEL_NUMBER = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int WEIGHT_WIDTH   = 3,
    parameter int CREDIT_MAX     = 4,
    parameter int CREDIT_WIDTH   = $clog2(CREDIT_MAX + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CHANNEL_NUMBER-1:0]              in_tvalid,
    output logic [CHANNEL_NUMBER-1:0]              in_tready,
    input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0]   in_tdata,
    input  logic [CHANNEL_NUMBER-1:0]              in_tlast,
    input  logic [CHANNEL_NUMBER*WEIGHT_WIDTH-1:0] weight,
    output logic                                   out_tvalid,
    output logic [DATA_WIDTH-1:0]                  out_tdata,
    output logic                                   out_tlast,
    input  logic                                   out_tready,
    input  logic                                   credit_return,
    output logic [CREDIT_WIDTH-1:0]                credits,
    output logic [CHANNEL_NUMBER-1:0]              grant,
    output logic                                   busy,
    output logic                                   credit_err
);

    // Handshake: a flit moves when out_tvalid & out_tready are both high on a
    // rising edge; in_tready[sel] mirrors that same event on the input side.

    localparam int SEL_W = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]              state;
    logic [SEL_W-1:0]        sel;
    logic [SEL_W-1:0]        ptr;
    logic [WEIGHT_WIDTH-1:0] quota;

    logic [SEL_W-1:0]        start;
    logic [SEL_W-1:0]        winner;
    logic                    found;
    logic [WEIGHT_WIDTH-1:0] win_weight;
    logic                    credit_ok;
    logic                    accept;
    int                      idx;

    // The current owner keeps the first look while it still has turns left.
    always_comb begin
        start = '0;
        if (quota != '0) begin
            start = ptr;
        end else if (ptr == SEL_W'(CHANNEL_NUMBER - 1)) begin
            start = '0;
        end else begin
            start = ptr + 1'b1;
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = start;
        idx    = 0;
        for (int k = 0; k < CHANNEL_NUMBER; k++) begin
            idx = int'(start) + k;
            if (idx >= CHANNEL_NUMBER) begin
                idx = idx - CHANNEL_NUMBER;
            end
            if (!found && in_tvalid[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
        win_weight = weight[int'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    assign busy      = (state == XFER);
    assign credit_ok = (credits != '0);
    assign accept    = busy & in_tvalid[sel] & credit_ok & out_tready;

    always_comb begin
        in_tready  = '0;
        grant      = '0;
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tlast  = 1'b0;
        if (busy) begin
            grant[sel]     = 1'b1;
            in_tready[sel] = out_tready & credit_ok;
            out_tvalid     = in_tvalid[sel] & credit_ok;
            out_tdata      = in_tdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            out_tlast      = in_tlast[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
            quota <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= XFER;
                        sel   <= winner;
                        if (winner == ptr && quota != '0) begin
                            quota <= quota - 1'b1;
                        end else begin
                            ptr   <= winner;
                            quota <= (win_weight == '0) ? '0 : win_weight - 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (accept && in_tlast[sel]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A return with the counter already full points at a downstream bookkeeping bug.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits    <= CREDIT_WIDTH'(CREDIT_MAX);
            credit_err <= 1'b0;
        end else if (credit_return && !accept && credits == CREDIT_WIDTH'(CREDIT_MAX)) begin
            credit_err <= 1'b1;
        end else if (accept && !credit_return) begin
            credits <= credits - 1'b1;
        end else if (credit_return && !accept) begin
            credits <= credits + 1'b1;
        end
    end

endmodule

// File: tb/tb_credit_wrr_scheduler.sv
// Directed bench for credit_wrr_scheduler: behavioural packet sources per
// channel, an in-order flit scoreboard and hand-computed credit/grant values.
module tb_credit_wrr_scheduler;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int WW = 3;
    localparam int CM = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_tvalid;
    logic [N-1:0]    in_tready;
    logic [N*DW-1:0] in_tdata;
    logic [N-1:0]    in_tlast;
    logic [N*WW-1:0] weight;
    logic            out_tvalid;
    logic [DW-1:0]   out_tdata;
    logic            out_tlast;
    logic            out_tready;
    logic            credit_return;
    logic [CW-1:0]   credits;
    logic [N-1:0]    grant;
    logic            busy;
    logic            credit_err;

    credit_wrr_scheduler #(
        .CHANNEL_NUMBER(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .CREDIT_MAX(CM)
    ) dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tlast(in_tlast), .weight(weight),
        .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tlast(out_tlast),
        .out_tready(out_tready), .credit_return(credit_return),
        .credits(credits), .grant(grant), .busy(busy), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int acc_count = 0;
    int base;

    logic [31:0] exp_q[$];
    logic        exp_last_q[$];

    int rem[N];
    int pkts[N];
    int plen[N];
    int pid[N];
    int fidx[N];
    logic auto_ret;
    logic prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && pkts[i] > 0) begin
                rem[i] = plen[i];
                pkts[i]--;
            end
            in_tvalid[i] = (rem[i] > 0);
            in_tlast[i]  = (rem[i] == 1);
            in_tdata[i*DW +: DW] = {4'(i), 12'(pid[i]), 16'(fidx[i])};
        end
    endtask

    task automatic add_pkts(input int ch, input int n, input int len);
        pkts[ch] += n;
        plen[ch] = len;
        apply_inputs();
    endtask

    task automatic expect_pkt(input int ch, input int p, input int len);
        for (int f = 0; f < len; f++) begin
            exp_q.push_back({4'(ch), 12'(p), 16'(f)});
            exp_last_q.push_back(f == len - 1);
        end
    endtask

    task automatic set_w(input int ch, input int w);
        weight[ch*WW +: WW] = WW'(w);
    endtask

    // One clock: observe at the falling edge, update sources just after the rising edge.
    task automatic tick();
        logic [N-1:0] acc;
        logic         fire;
        logic [31:0]  e;
        @(negedge clk);
        if (prev_last) check("idle_gap_busy", 32'(busy), 32'd0);
        fire = out_tvalid & out_tready;
        acc  = in_tvalid & in_tready;
        if (fire) begin
            acc_count++;
            check("accept_matches_grant", 32'(acc), 32'(grant));
            check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("flit_data", out_tdata, e);
                check("grant", 32'(grant), 32'd1 << e[31:28]);
                check("tlast", 32'(out_tlast), 32'(exp_last_q.pop_front()));
            end
        end
        prev_last = fire & out_tlast;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                fidx[i]++;
                rem[i]--;
                if (rem[i] == 0) begin
                    pid[i]++;
                    fidx[i] = 0;
                end
            end
        end
        credit_return = auto_ret & fire;
        apply_inputs();
    endtask

    task automatic run_drain(input int budget);
        int c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            tick();
            c++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; pkts[i] = 0; plen[i] = 1; pid[i] = 0; fidx[i] = 0;
            set_w(i, 1);
        end
        exp_q.delete();
        exp_last_q.delete();
        credit_return = 1'b0;
        auto_ret  = 1'b0;
        prev_last = 1'b0;
        out_tready = 1'b1;
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        weight = '0;
        do_reset();
        check("rst_out_tvalid", 32'(out_tvalid), 32'd0);
        check("rst_in_tready", 32'(in_tready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_credit_err", 32'(credit_err), 32'd0);

        // ch0 then ch2, three flits each, credits recycled one cycle after use.
        do_reset();
        auto_ret = 1'b1;
        add_pkts(0, 1, 3);
        expect_pkt(0, 0, 3);
        tick();
        check("t1_grant_ch0", 32'(grant), 32'h01);
        add_pkts(2, 1, 3);
        expect_pkt(2, 0, 3);
        run_drain(30);
        tick();
        tick();
        check("t1_credits_restored", 32'(credits), 32'd4);

        // weight[1]=2, weight[3]=1: packet order 1,1,3,1,1,3.
        do_reset();
        auto_ret = 1'b1;
        set_w(1, 2);
        set_w(3, 1);
        add_pkts(1, 4, 1);
        add_pkts(3, 2, 1);
        expect_pkt(1, 0, 1);
        expect_pkt(1, 1, 1);
        expect_pkt(3, 0, 1);
        expect_pkt(1, 2, 1);
        expect_pkt(1, 3, 1);
        expect_pkt(3, 1, 1);
        run_drain(60);

        // Credit starvation: 6-flit packet, only 4 credits, then two returns.
        do_reset();
        add_pkts(0, 1, 6);
        expect_pkt(0, 0, 6);
        base = acc_count;
        tick();
        repeat (4) tick();
        check("t3_four_passed", 32'(acc_count - base), 32'd4);
        check("t3_credits_zero", 32'(credits), 32'd0);
        tick();
        check("t3_stall_tvalid", 32'(out_tvalid), 32'd0);
        check("t3_stall_busy", 32'(busy), 32'd1);
        check("t3_stall_grant", 32'(grant), 32'h01);
        check("t3_stall_in_tready", 32'(in_tready), 32'd0);
        credit_return = 1'b1;
        tick();
        check("t3_credit_one", 32'(credits), 32'd1);
        credit_return = 1'b1;
        tick();
        check("t3_accept_and_return", 32'(credits), 32'd1);
        tick();
        check("t3_credits_end", 32'(credits), 32'd0);
        check("t3_all_flits", 32'(exp_q.size()), 32'd0);
        check("t3_idle_after", 32'(busy), 32'd0);

        // Accept and return in the same cycle at credits=2.
        do_reset();
        add_pkts(0, 1, 4);
        expect_pkt(0, 0, 4);
        tick();
        tick();
        tick();
        check("t4_credits_two", 32'(credits), 32'd2);
        credit_return = 1'b1;
        tick();
        check("t4_credits_hold", 32'(credits), 32'd2);
        tick();
        check("t4_credits_one", 32'(credits), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);

        // Return while full sets the sticky error.
        do_reset();
        tick();
        check("t5_credits_full", 32'(credits), 32'd4);
        credit_return = 1'b1;
        tick();
        check("t5_credits_sat", 32'(credits), 32'd4);
        check("t5_err_set", 32'(credit_err), 32'd1);
        repeat (3) tick();
        check("t5_err_sticky", 32'(credit_err), 32'd1);
        do_reset();
        check("t5_err_cleared", 32'(credit_err), 32'd0);

        // Reset mid-packet on ch4, then ch0 and ch3 request together.
        do_reset();
        add_pkts(4, 1, 5);
        expect_pkt(4, 0, 5);
        base = acc_count;
        tick();
        tick();
        tick();
        check("t6_two_passed", 32'(acc_count - base), 32'd2);
        check("t6_credits_two", 32'(credits), 32'd2);
        rst = 1'b1;
        rem[4] = 0;
        pkts[4] = 0;
        exp_q.delete();
        exp_last_q.delete();
        apply_inputs();
        @(posedge clk);
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_grant", 32'(grant), 32'd0);
        check("t6_credits", 32'(credits), 32'd4);
        check("t6_out_tvalid", 32'(out_tvalid), 32'd0);
        rst = 1'b0;
        // ptr=0, quota=0: search starts at ch1 and reaches ch3 before ch0.
        add_pkts(0, 1, 1);
        add_pkts(3, 1, 1);
        expect_pkt(3, 0, 1);
        expect_pkt(0, 0, 1);
        run_drain(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
